sram_arbiter: RTL and testbench
===============================

# sram_arbiter

Single-port access controller for one synchronous on-chip SRAM with 1-cycle read latency. Shares the RAM between a high-priority read-only video/scanout requester (port A) and a read/write CPU requester (port B), with a bounded-starvation guard for B. Also provides a hardware clear sequencer that fills the whole RAM with a constant. Sits between the RAM instance and the CPU bus decode / video fetch logic.

## Interface
- DATA_WIDTH, 8, RAM word width
- ADDR_WIDTH, 10, RAM address width; depth = 2**ADDR_WIDTH
- STARVE_MAX, 4, consecutive denied B cycles before B is forced through (1..15)
- CLEAR_VALUE, 0, word written by the clear sequencer
- clk  in  1  single clock; all logic on posedge
- reset_n  in  1  synchronous, active-low reset
- clear_start  in  1  one-cycle pulse; starts a full-RAM clear
- clear_busy  out  1  high while a clear is in progress
- a_req  in  1  port A read request
- a_addr  in  ADDR_WIDTH  port A address
- a_ack  out  1  port A request accepted this cycle
- a_valid  out  1  port A read data valid on a_q
- a_q  out  DATA_WIDTH  port A read data
- b_req  in  1  port B request
- b_we  in  1  port B write (1) / read (0)
- b_addr  in  ADDR_WIDTH  port B address
- b_data  in  DATA_WIDTH  port B write data
- b_ack  out  1  port B request accepted this cycle
- b_valid  out  1  port B read data valid on b_q (reads only)
- b_q  out  DATA_WIDTH  port B read data
- ram_addr  out  ADDR_WIDTH  to RAM ADDR
- ram_data  out  DATA_WIDTH  to RAM DATA
- ram_cen  out  1  to RAM cen
- ram_we  out  1  to RAM we
- ram_q  in  DATA_WIDTH  from RAM Q

## Operation
- States: ARB, CLEAR. Reset -> ARB.
- ARB: per cycle, at most one grant. Default priority A > B. Starve counter counts cycles with b_req high and b_ack low; when count == STARVE_MAX and b_req high, B wins that cycle over A. Counter clears on b_ack or b_req low; saturates, never wraps.
- Grant is combinational: ack, ram_addr, ram_cen, ram_we, ram_data driven from the winner in the same cycle. A grant: ram_we=0. B grant: ram_we=b_we, ram_data=b_data. No grant: ram_cen=0, ram_we=0, ram_addr holds last value.
- Requesters hold req/addr/data stable until ack; after ack they may drop req or present a new request the next cycle (back-to-back one per cycle allowed).
- clear_start in ARB -> CLEAR next cycle; address counter starts at 0. In the cycle clear_start is seen, normal arbitration still occurs.
- CLEAR: every cycle ram_cen=1, ram_we=1, ram_addr=counter, ram_data=CLEAR_VALUE; counter +1. After writing address 2**ADDR_WIDTH-1 -> ARB. No acks during CLEAR; requests wait. clear_start during CLEAR ignored (no restart). Starve counter frozen during CLEAR.
- Read-during-write same address returns old data (RAM behaviour, passed through).

## Timing
- Read latency: ack in cycle N -> valid in N+1; a_q/b_q = ram_q in N+1. Valid flags are registers; data is combinational from ram_q, meaningful only while valid.
- Write: committed at end of ack cycle; b_valid not asserted.
- Clear: exactly 2**ADDR_WIDTH cycles with clear_busy high; clear_busy rises the cycle after clear_start.
- Reset values: a_ack=b_ack=0, a_valid=b_valid=0, clear_busy=0, ram_cen=ram_we=0, ram_addr=0, ram_data=0, starve counter 0, clear counter 0.
- Reset mid-clear aborts immediately: ARB, clear_busy=0, RAM contents partially cleared (not restored).
- Reset in cycle after an ack suppresses the pending valid.

## Structure
- Shared package: state encoding (ARB, CLEAR) and starve counter width constant (4 bits).
- One flat module; no sub-module needed. RAM instance lives in the parent, not inside.

## Test plan
- Reset, then A reads 0x010 and B reads 0x020 on alternate cycles -> each ack same cycle, valid next cycle, data matches preloaded hex.
- B writes 0x5A to 0x3FF, then B reads 0x3FF -> b_valid next cycle with b_q=0x5A; no b_valid on the write.
- A and B request continuously, STARVE_MAX=4 -> B acked on every 5th cycle, A on the other 4; counter resets after each B grant.
- clear_start pulse -> clear_busy high for exactly 1024 cycles, no acks meanwhile; afterwards reads of 0x000, 0x1FF, 0x3FF return CLEAR_VALUE.
- clear_start again during clear -> ignored, busy still ends at original count.
- reset_n low at clear address 0x100 -> clear_busy=0 next cycle; 0x0FF reads CLEAR_VALUE, 0x100+ retain prior contents.

Source files
------------

// File: rtl/sram_arbiter_pkg.sv
// Shared definitions for the SRAM access arbiter: controller states and the
// width of the B-port starvation counter.
package sram_arbiter_pkg;

    typedef enum logic {
        ST_ARB   = 1'b0,
        ST_CLEAR = 1'b1
    } arb_state_t;

    localparam int STARVE_W = 4;

endpackage

// File: rtl/sram_arbiter.sv
// Single-port SRAM access controller: read-only port A has priority over
// read/write port B, B is forced through after STARVE_MAX denied cycles, and
// a clear sequencer can fill the whole RAM with CLEAR_VALUE.
//
// state    | meaning
// ST_ARB   | normal arbitration, at most one grant per cycle
// ST_CLEAR | one write of CLEAR_VALUE per cycle, all requests held off
module sram_arbiter
    import sram_arbiter_pkg::*;
#(
    parameter int                  DATA_WIDTH  = 8,
    parameter int                  ADDR_WIDTH  = 10,
    parameter int                  STARVE_MAX  = 4,
    parameter logic [DATA_WIDTH-1:0] CLEAR_VALUE = '0
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  clear_start,
    output logic                  clear_busy,
    input  logic                  a_req,
    input  logic [ADDR_WIDTH-1:0] a_addr,
    output logic                  a_ack,
    output logic                  a_valid,
    output logic [DATA_WIDTH-1:0] a_q,
    input  logic                  b_req,
    input  logic                  b_we,
    input  logic [ADDR_WIDTH-1:0] b_addr,
    input  logic [DATA_WIDTH-1:0] b_data,
    output logic                  b_ack,
    output logic                  b_valid,
    output logic [DATA_WIDTH-1:0] b_q,
    output logic [ADDR_WIDTH-1:0] ram_addr,
    output logic [DATA_WIDTH-1:0] ram_data,
    output logic                  ram_cen,
    output logic                  ram_we,
    input  logic [DATA_WIDTH-1:0] ram_q
);

    arb_state_t            state_q, state_d;
    logic [STARVE_W-1:0]   starve_q;
    logic [ADDR_WIDTH-1:0] clr_cnt_q;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic                  a_valid_q, b_valid_q;
    logic                  grant_a, grant_b, b_force;

    // Every output is gated by reset_n so the reset values appear while reset is held.
    always_comb begin
        state_d    = state_q;
        grant_a    = 1'b0;
        grant_b    = 1'b0;
        b_force    = 1'b0;
        clear_busy = 1'b0;
        ram_cen    = 1'b0;
        ram_we     = 1'b0;
        ram_addr   = addr_q;
        ram_data   = '0;
        if (!reset_n) begin
            ram_addr = '0;
        end else begin
            case (state_q)
                ST_ARB: begin
                    b_force = b_req && (starve_q == STARVE_W'(STARVE_MAX));
                    if (b_force)    grant_b = 1'b1;
                    else if (a_req) grant_a = 1'b1;
                    else if (b_req) grant_b = 1'b1;
                    if (clear_start) state_d = ST_CLEAR;
                end
                ST_CLEAR: begin
                    clear_busy = 1'b1;
                    ram_cen    = 1'b1;
                    ram_we     = 1'b1;
                    ram_addr   = clr_cnt_q;
                    ram_data   = CLEAR_VALUE;
                    if (clr_cnt_q == '1) state_d = ST_ARB;
                end
                default: state_d = ST_ARB;
            endcase
            if (grant_a) begin
                ram_cen  = 1'b1;
                ram_addr = a_addr;
            end else if (grant_b) begin
                ram_cen  = 1'b1;
                ram_we   = b_we;
                ram_addr = b_addr;
                ram_data = b_data;
            end
        end
    end

    assign a_ack   = grant_a;
    assign b_ack   = grant_b;
    assign a_valid = a_valid_q && reset_n;
    assign b_valid = b_valid_q && reset_n;
    assign a_q     = ram_q;
    assign b_q     = ram_q;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q   <= ST_ARB;
            starve_q  <= '0;
            clr_cnt_q <= '0;
            addr_q    <= '0;
            a_valid_q <= 1'b0;
            b_valid_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            addr_q    <= ram_addr;
            a_valid_q <= grant_a;
            b_valid_q <= grant_b && !b_we;
            clr_cnt_q <= (state_q == ST_CLEAR) ? clr_cnt_q + 1'b1 : '0;
            // Starvation count only moves in ARB; it saturates rather than wrapping.
            if (state_q == ST_ARB) begin
                if (grant_b || !b_req)  starve_q <= '0;
                else if (starve_q != '1) starve_q <= starve_q + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_sram_arbiter.sv
// Directed self-checking bench for sram_arbiter with a 1-cycle-latency RAM
// model preloaded with addr[7:0] ^ 8'hA5.
module tb_sram_arbiter;

    logic       clk = 1'b0;
    logic       reset_n;
    logic       clear_start;
    logic       clear_busy;
    logic       a_req;
    logic [9:0] a_addr;
    logic       a_ack, a_valid;
    logic [7:0] a_q;
    logic       b_req, b_we;
    logic [9:0] b_addr;
    logic [7:0] b_data;
    logic       b_ack, b_valid;
    logic [7:0] b_q;
    logic [9:0] ram_addr;
    logic [7:0] ram_data;
    logic       ram_cen, ram_we;
    logic [7:0] ram_q;

    logic [7:0] mem [0:1023];
    logic       preload;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    sram_arbiter #(
        .DATA_WIDTH (8),
        .ADDR_WIDTH (10),
        .STARVE_MAX (4),
        .CLEAR_VALUE(8'h00)
    ) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .clear_start(clear_start),
        .clear_busy (clear_busy),
        .a_req      (a_req),
        .a_addr     (a_addr),
        .a_ack      (a_ack),
        .a_valid    (a_valid),
        .a_q        (a_q),
        .b_req      (b_req),
        .b_we       (b_we),
        .b_addr     (b_addr),
        .b_data     (b_data),
        .b_ack      (b_ack),
        .b_valid    (b_valid),
        .b_q        (b_q),
        .ram_addr   (ram_addr),
        .ram_data   (ram_data),
        .ram_cen    (ram_cen),
        .ram_we     (ram_we),
        .ram_q      (ram_q)
    );

    always @(posedge clk) begin
        if (preload) begin
            for (int i = 0; i < 1024; i++) mem[i] <= i[7:0] ^ 8'hA5;
        end else if (ram_cen) begin
            if (ram_we) mem[ram_addr] <= ram_data;
            ram_q <= mem[ram_addr];
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        int  busy_cnt;
        bit  done;
        bit  ack_seen;

        reset_n = 1'b0; clear_start = 1'b0; preload = 1'b1;
        a_req = 1'b1; a_addr = 10'h010;
        b_req = 1'b0; b_we = 1'b0; b_addr = '0; b_data = '0;
        @(negedge clk); #1;
        chk("rst_a_ack", a_ack, 0);
        chk("rst_b_ack", b_ack, 0);
        chk("rst_a_valid", a_valid, 0);
        chk("rst_b_valid", b_valid, 0);
        chk("rst_busy", clear_busy, 0);
        chk("rst_cen", ram_cen, 0);
        chk("rst_we", ram_we, 0);
        chk("rst_addr", ram_addr, 0);
        chk("rst_data", ram_data, 0);
        @(negedge clk); preload = 1'b0;

        // A reads 0x010, then B reads 0x020
        @(negedge clk); reset_n = 1'b1; a_req = 1'b1; a_addr = 10'h010; #1;
        chk("a_rd_ack", a_ack, 1);
        chk("a_rd_b_ack", b_ack, 0);
        chk("a_rd_addr", ram_addr, 10'h010);
        chk("a_rd_cen", ram_cen, 1);
        chk("a_rd_we", ram_we, 0);
        @(negedge clk); a_req = 1'b0; b_req = 1'b1; b_we = 1'b0; b_addr = 10'h020; #1;
        chk("b_rd_ack", b_ack, 1);
        chk("a_rd_valid", a_valid, 1);
        chk("a_rd_q", a_q, 8'hB5);
        @(negedge clk); b_req = 1'b0; #1;
        chk("b_rd_valid", b_valid, 1);
        chk("b_rd_q", b_q, 8'h85);
        chk("idle_cen", ram_cen, 0);
        chk("idle_addr_hold", ram_addr, 10'h020);
        chk("idle_a_valid", a_valid, 0);

        // B write then read back at the top address
        @(negedge clk); b_req = 1'b1; b_we = 1'b1; b_addr = 10'h3FF; b_data = 8'h5A; #1;
        chk("b_wr_ack", b_ack, 1);
        chk("b_wr_we", ram_we, 1);
        chk("b_wr_data", ram_data, 8'h5A);
        @(negedge clk); b_we = 1'b0; b_data = 8'h00; #1;
        chk("b_wr_no_valid", b_valid, 0);
        chk("b_rd2_ack", b_ack, 1);
        @(negedge clk); b_req = 1'b0; #1;
        chk("b_rd2_valid", b_valid, 1);
        chk("b_rd2_q", b_q, 8'h5A);

        // Continuous contention: B wins every fifth cycle
        @(negedge clk); a_req = 1'b1; a_addr = 10'h001; b_req = 1'b1; b_addr = 10'h002; #1;
        for (int i = 0; i < 10; i++) begin
            if (i != 0) begin @(negedge clk); #1; end
            chk($sformatf("starve_b_ack_%0d", i), b_ack, (i % 5 == 4) ? 1 : 0);
            chk($sformatf("starve_a_ack_%0d", i), a_ack, (i % 5 == 4) ? 0 : 1);
        end

        // Clear: arbitration still happens in the clear_start cycle
        @(negedge clk); b_req = 1'b0; a_addr = 10'h010; clear_start = 1'b1; #1;
        chk("clr_start_a_ack", a_ack, 1);
        chk("clr_start_busy", clear_busy, 0);
        busy_cnt = 0; done = 1'b0; ack_seen = 1'b0;
        for (int k = 0; k < 1100 && !done; k++) begin
            @(negedge clk); clear_start = (k == 5); #1;
            if (k == 0) begin
                chk("clr_first_addr", ram_addr, 0);
                chk("clr_first_we", ram_we, 1);
                chk("clr_first_cen", ram_cen, 1);
            end
            if (clear_busy) begin
                busy_cnt++;
                if (a_ack || b_ack) ack_seen = 1'b1;
            end else begin
                done = 1'b1;
            end
        end
        clear_start = 1'b0;
        chk("clr_ended", done, 1);
        chk("clr_busy_cycles", busy_cnt, 1024);
        chk("clr_no_acks", ack_seen, 0);
        chk("post_clr_a_ack", a_ack, 1);
        @(negedge clk); a_addr = 10'h1FF; #1;
        chk("post_clr_q_010", a_q, 8'h00);
        @(negedge clk); a_addr = 10'h3FF; #1;
        chk("post_clr_q_1ff", a_q, 8'h00);
        @(negedge clk); a_addr = 10'h000; #1;
        chk("post_clr_q_3ff", a_q, 8'h00);
        @(negedge clk); a_req = 1'b0; #1;
        chk("post_clr_valid", a_valid, 1);
        chk("post_clr_q_000", a_q, 8'h00);

        // Reset aborts a clear at address 0x100
        @(negedge clk); preload = 1'b1;
        @(negedge clk); preload = 1'b0; clear_start = 1'b1;
        for (int k = 0; k <= 256; k++) begin
            @(negedge clk); clear_start = 1'b0; #1;
        end
        chk("abort_addr", ram_addr, 10'h100);
        chk("abort_busy_before", clear_busy, 1);
        reset_n = 1'b0; #1;
        chk("abort_cen_in_reset", ram_cen, 0);
        @(negedge clk); reset_n = 1'b1; #1;
        chk("abort_busy_after", clear_busy, 0);
        chk("abort_we_after", ram_we, 0);
        @(negedge clk); b_req = 1'b1; b_we = 1'b0; b_addr = 10'h0FF; #1;
        chk("abort_rd_ack", b_ack, 1);
        @(negedge clk); b_addr = 10'h100; #1;
        chk("abort_q_0ff", b_q, 8'h00);
        @(negedge clk); b_addr = 10'h101; #1;
        chk("abort_q_100", b_q, 8'hA5);
        @(negedge clk); b_req = 1'b0; #1;
        chk("abort_q_101", b_q, 8'hA4);

        // Reset in the cycle after an ack drops the pending valid
        @(negedge clk); a_req = 1'b1; a_addr = 10'h010; #1;
        chk("sup_a_ack", a_ack, 1);
        @(negedge clk); a_req = 1'b0; reset_n = 1'b0; #1;
        chk("sup_valid_in_reset", a_valid, 0);
        @(negedge clk); reset_n = 1'b1; #1;
        chk("sup_valid_after", a_valid, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout checks=%0d", checks);
        $fatal(1, "simulation time limit reached");
    end

endmodule
